// File: rtl/uart_tx_if.sv
// Producer-side handshake bundle for uart_tx.
// The producer drives tx_start/tx_data and watches tx_ready/tx_done.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_ready,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter driven by an external baud square wave.
// Frame: start bit, DATA_BITS data bits LSB-first, optional even parity,
// STOP_BITS stop bits. Bit boundaries are the rising edges of baud.
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit).
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     baud,
  uart_tx_if.slave bus,
  output logic     tx
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif
  localparam logic [2:0] STOP   = 3'd5;

  logic                 baud_q;
  logic                 baud_rise;
  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     stop_cnt;
  logic                 tx_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign baud_rise    = baud & ~baud_q;
  assign accept       = bus.tx_start & ready_q;
  assign tx           = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_done  = done_q;

  // Delay baud by one clk so its rising edge can be detected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) baud_q <= 1'b0;
    else        baud_q <= baud;
  end

  // Frame sequencer: every bit transition waits for a baud rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            shift    <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^bus.tx_data;
`endif
            ready_q  <= 1'b0;
            state    <= SYNC;
          end
        end
        // Hold off the start bit until a bit boundary so it lasts a full period.
        SYNC: begin
          if (baud_rise) begin
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_rise) begin
            tx_q    <= shift[0];
            shift   <= {1'b0, shift[DATA_BITS-1:1]};
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_rise) begin
            if (bit_cnt < LAST_BIT) begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= shift[0];
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
            end else begin
`ifdef UART_TX_PARITY_EN
              tx_q     <= parity_q;
              state    <= PARITY;
`else
              tx_q     <= 1'b1;
              stop_cnt <= '0;
              state    <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_rise) begin
            tx_q     <= 1'b1;
            stop_cnt <= '0;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (baud_rise) begin
            if (stop_cnt < LAST_STOP) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed-plus-random bench for uart_tx; expected line bits come from a
// frame model built as a bit queue (start, data LSB-first, parity, stops).
module tb_uart_tx;

  localparam int DB   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int SB   = 2;
  localparam int PB   = 1;
`else
  localparam int SB   = 1;
  localparam int PB   = 0;
`endif
  localparam int HALF = 16;
  localparam int BITP = 2 * HALF;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic baud    = 1'b0;
  logic baud_en = 1'b1;
  logic tx;
  int   bcnt    = 0;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_if #(.DATA_BITS(DB)) bus ();

  uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .baud  (baud),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  // Baud square wave: toggles every HALF clocks while enabled.
  always @(posedge clk) begin
    if (baud_en) begin
      if (bcnt == HALF - 1) begin
        bcnt <= 0;
        baud <= ~baud;
      end else begin
        bcnt <= bcnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request in the current cycle; it is taken on the next edge.
  task automatic send(input logic [DB-1:0] d);
    chk("ready_before_start", {31'd0, bus.tx_ready}, 32'd1);
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    chk("ready_low_after_accept", {31'd0, bus.tx_ready}, 32'd0);
    chk("done_low_after_accept", {31'd0, bus.tx_done}, 32'd0);
  endtask

  // Follow one frame on the line and compare against the model.
  task automatic expect_frame(input logic [DB-1:0] d, input int lat_min, input int lat_max,
                              input int inj_bit, input int abort_bit, output bit aborted);
    bit bits[$];
    int lat;
    bit ok;
    aborted = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PB != 0) bits.push_back(^d);
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);

    lat = 0;
    while (tx !== 1'b0 && lat <= lat_max) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("start_latency_%0d_in_%0d_%0d", lat, lat_min, lat_max),
        {31'd0, (lat >= lat_min && lat <= lat_max)}, 32'd1);
    if (tx !== 1'b0) return;

    for (int k = 0; k < bits.size(); k++) begin
      ok = 1'b1;
      for (int j = 0; j < BITP; j++) begin
        if (k == abort_bit && j == 10) begin
          reset = 1'b0;
          #1;
          chk("abort_tx_high", {31'd0, tx}, 32'd1);
          chk("abort_ready_high", {31'd0, bus.tx_ready}, 32'd1);
          chk("abort_no_done", {31'd0, bus.tx_done}, 32'd0);
          aborted = 1'b1;
          return;
        end
        ok &= (tx === bits[k]) && (bus.tx_ready === 1'b0) && (bus.tx_done === 1'b0);
        if (k == inj_bit && j == 5) begin
          bus.tx_start = 1'b1;
          bus.tx_data  = 8'h3C;
        end else begin
          bus.tx_start = 1'b0;
        end
        @(posedge clk); #1;
      end
      chk($sformatf("data_%02h_bit%0d_exp%0d_full_period", d, k, bits[k]), {31'd0, ok}, 32'd1);
    end
    chk("done_pulse_at_stop_end", {31'd0, bus.tx_done}, 32'd1);
    chk("ready_at_stop_end", {31'd0, bus.tx_ready}, 32'd1);
    chk("line_idle_at_stop_end", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    bit ok;
    bit ab;
    logic [DB-1:0] d;
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;

    // Reset held with baud running.
    ok = 1'b1;
    repeat (80) begin
      @(posedge clk); #1;
      ok &= (tx === 1'b1) && (bus.tx_ready === 1'b1) && (bus.tx_done === 1'b0);
    end
    chk("reset_hold_outputs", {31'd0, ok}, 32'd1);

    @(negedge clk) reset = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      ok &= (tx === 1'b1) && (bus.tx_ready === 1'b1) && (bus.tx_done === 1'b0);
    end
    chk("idle_after_release", {31'd0, ok}, 32'd1);

    // Basic frame.
    send(8'hA5);
    expect_frame(8'hA5, 1, BITP + 1, -1, -1, ab);
    @(posedge clk); #1;
    chk("done_one_clk_wide", {31'd0, bus.tx_done}, 32'd0);

    // Request while busy is dropped.
    send(8'hFF);
    expect_frame(8'hFF, 1, BITP + 1, 3, -1, ab);
    ok = 1'b1;
    repeat (80) begin
      @(posedge clk); #1;
      ok &= (tx === 1'b1) && (bus.tx_ready === 1'b1);
    end
    chk("busy_request_not_queued", {31'd0, ok}, 32'd1);

    // Back-to-back: second request in the cycle ready rises.
    send(8'h81);
    expect_frame(8'h81, 1, BITP + 1, -1, -1, ab);
    send(8'h00);
    expect_frame(8'h00, BITP - 1, BITP - 1, -1, -1, ab);
    @(posedge clk); #1;

    // Baud stuck: the frame waits in its pre-start phase.
    baud_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h5A);
    ok = 1'b1;
    repeat (200) begin
      @(posedge clk); #1;
      ok &= (tx === 1'b1) && (bus.tx_ready === 1'b0) && (bus.tx_done === 1'b0);
    end
    chk("stuck_baud_holds", {31'd0, ok}, 32'd1);
    baud_en = 1'b1;
    expect_frame(8'h5A, 1, BITP + 2, -1, -1, ab);
    @(posedge clk); #1;

    // Parity-relevant pattern (odd number of ones).
    send(8'h07);
    expect_frame(8'h07, 1, BITP + 1, -1, -1, ab);
    @(posedge clk); #1;

    // Random frames.
    for (int n = 0; n < 5; n++) begin
      d = DB'($urandom);
      send(d);
      expect_frame(d, 1, BITP + 1, -1, -1, ab);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end

    // Reset during data bit 3.
    send(8'hC3);
    expect_frame(8'hC3, 1, BITP + 1, -1, 4, ab);
    chk("abort_reached", {31'd0, ab}, 32'd1);
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      ok &= (tx === 1'b1) && (bus.tx_ready === 1'b1) && (bus.tx_done === 1'b0);
    end
    chk("abort_quiet_in_reset", {31'd0, ok}, 32'd1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    send(8'h96);
    expect_frame(8'h96, 1, BITP + 1, -1, -1, ab);
    @(posedge clk); #1;
    chk("post_abort_done_width", {31'd0, bus.tx_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter sitting directly downstream of the transmit baud generator.
- Consumes the generator's `baud` square wave; each rising edge of `baud` marks one bit-period boundary.
- Serialises a parallel byte from the AES datapath onto the `tx` line as start, data LSB-first, optional parity, and stop bits.
- Uses a ready/start handshake toward the producer.

Parameters:
- DATA_BITS, 8, number of data bits per frame (legal 5–8).
- STOP_BITS, 1, number of stop-bit periods (legal 1 or 2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- baud  input  1  bit-rate square wave from the baud generator, synchronous to clk; only its rising edges are used.
- tx_start  input  1  single-cycle request; honoured only when tx_ready=1.
- tx_data  input  DATA_BITS  byte to send; sampled in the cycle tx_start is accepted.
- tx_ready  output  1  high when idle and able to accept a frame.
- tx_done  output  1  one-clk pulse when the final stop bit period completes.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, tx_ready=1, tx_done=0.
  - state=IDLE, baud_q=0, shift register=0, bit and stop counters=0.
- Edge detect: baud_q <= baud every clk; baud_rise = baud & ~baud_q (combinational). All bit timing uses baud_rise only.
- Handshake:
  - A frame is accepted on a clk edge where tx_start=1 and tx_ready=1.
  - tx_data is latched into the shift register and tx_ready falls on that same edge.
  - tx_start while tx_ready=0 is ignored; no queueing.
- States:
  - IDLE: tx=1. On accept, go to SYNC.
  - SYNC: wait for baud_rise, so the start bit is aligned to a full bit period. On baud_rise: tx<=0, go to START.
  - START: on baud_rise: tx<=shift[0], shift right, bit_cnt<=0, go to DATA.
  - DATA: on each baud_rise:
    - If bit_cnt < DATA_BITS-1: bit_cnt+1, tx<=next LSB.
    - Otherwise: go to PARITY (if enabled, tx<=parity) or STOP (tx<=1, stop_cnt<=0).
  - PARITY: on baud_rise: tx<=1, stop_cnt<=0, go to STOP.
  - STOP: tx=1. On baud_rise:
    - If stop_cnt < STOP_BITS-1: stop_cnt+1.
    - Otherwise: tx_done=1 for exactly one clk, tx_ready<=1, go to IDLE.
- Timing:
  - tx changes exactly one clk edge after the clk in which baud_rise is asserted.
  - Every bit lasts exactly one baud period.
  - Acceptance-to-start-bit latency: 1 to 1 baud period + 1 clk.
- Back-to-back frames:
  - tx_start is allowed in the same cycle tx_ready rises; it is accepted on the next clk edge.
  - The line stays high until the next baud_rise, so there is no glitch and no shortened stop bit.
- Counters are sized to ceil(log2(DATA_BITS)); no wrap occurs because each is bounded by its state.
- Reset asserted mid-frame: immediate abort, tx=1, tx_ready=1. No tx_done pulse is issued for the aborted frame.
- baud stuck high or low: the FSM holds its current state and tx level indefinitely.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is present.
  - The parity bit is even parity (XOR of all DATA_BITS data bits).
  - Parity is computed from tx_data at acceptance and held in a register.
  - The parity bit is sent for one baud period between the last data bit and the first stop bit.
- Undefined:
  - The PARITY state and parity register are not built.
  - DATA transitions directly to STOP.

Test Plan:
- Reset check: hold reset=0 with baud toggling -> tx=1, tx_ready=1, tx_done=0 throughout. Release reset -> outputs unchanged until tx_start.
- Basic frame: baud toggles every 16 clk (32-clk period), send tx_data=0xA5, no parity, STOP_BITS=1.
  - tx sequence, each 32 clk: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done pulses once, 1 clk wide, at the end of the stop bit.
  - tx_ready=0 from acceptance until that pulse.
- Busy rejection: issue tx_start with 0x3C mid-frame of 0xFF -> 0x3C never appears on tx; the 0xFF frame completes intact.
- Back-to-back: assert tx_start with 0x00 in the cycle tx_ready rises after 0x81 -> stop bit of the first frame is a full 32 clk; second start bit begins on the next baud rise.
- Parity and two stop bits: UART_TX_PARITY_EN defined, STOP_BITS=2, tx_data=0x07 -> parity bit=1, followed by two 32-clk high stop periods, then tx_done.
- Mid-frame reset: pull reset low during data bit 3 -> tx=1 and tx_ready=1 asynchronously, with no tx_done pulse. A new frame after release transmits correctly.
